// File: rtl/instr_decode.sv
// Registered 6502 instruction decoder: maps an opcode byte to a mnemonic code,
// an addressing-mode code and an illegal flag, with one cycle of latency.
module instr_decode (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] instr,
    output logic [5:0] opcode,
    output logic [3:0] mode,
    output logic       illegal
);

    typedef enum logic [5:0] {
        OPC_U,
        OPC_ADC, OPC_AND, OPC_ASL, OPC_BCC, OPC_BCS, OPC_BEQ, OPC_BIT, OPC_BMI,
        OPC_BNE, OPC_BPL, OPC_BRK, OPC_BVC, OPC_BVS, OPC_CLC, OPC_CLD, OPC_CLI,
        OPC_CLV, OPC_CMP, OPC_CPX, OPC_CPY, OPC_DEC, OPC_DEX, OPC_DEY, OPC_EOR,
        OPC_INC, OPC_INX, OPC_INY, OPC_JMP, OPC_JSR, OPC_LDA, OPC_LDX, OPC_LDY,
        OPC_LSR, OPC_NOP, OPC_ORA, OPC_PHA, OPC_PHP, OPC_PLA, OPC_PLP, OPC_ROL,
        OPC_ROR, OPC_RTI, OPC_RTS, OPC_SBC, OPC_SEC, OPC_SED, OPC_SEI, OPC_STA,
        OPC_STX, OPC_STY, OPC_TAX, OPC_TAY, OPC_TSX, OPC_TXA, OPC_TXS, OPC_TYA
    } opc_t;

    typedef enum logic [3:0] {
        AM_U, AM_IMP, AM_ACC, AM_IMM, AM_ZP, AM_ZPX, AM_ZPY, AM_ABS,
        AM_ABSX, AM_ABSY, AM_IND, AM_INDX, AM_INDY, AM_REL
    } addmod_t;

    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    logic [5:0] dec_op;
    logic [3:0] dec_mode;
    logic [5:0] grp_op;

    logic [5:0] opcode_q, opcode_d;
    logic [3:0] mode_q, mode_d;
    logic       illegal_q, illegal_d;

    assign aaa = instr[7:5];
    assign bbb = instr[4:2];
    assign cc  = instr[1:0];

    // Mnemonic selected by aaa for the two regular groups.
    always_comb begin
        grp_op = OPC_U;
        if (cc == 2'b01) begin
            case (aaa)
                3'd0:    grp_op = OPC_ORA;
                3'd1:    grp_op = OPC_AND;
                3'd2:    grp_op = OPC_EOR;
                3'd3:    grp_op = OPC_ADC;
                3'd4:    grp_op = OPC_STA;
                3'd5:    grp_op = OPC_LDA;
                3'd6:    grp_op = OPC_CMP;
                default: grp_op = OPC_SBC;
            endcase
        end else begin
            case (aaa)
                3'd0:    grp_op = OPC_ASL;
                3'd1:    grp_op = OPC_ROL;
                3'd2:    grp_op = OPC_LSR;
                3'd3:    grp_op = OPC_ROR;
                3'd4:    grp_op = OPC_STX;
                3'd5:    grp_op = OPC_LDX;
                3'd6:    grp_op = OPC_DEC;
                default: grp_op = OPC_INC;
            endcase
        end
    end

    // Every documented opcode has a non-zero mode, so mode==0 alone marks illegal.
    always_comb begin
        dec_op   = OPC_U;
        dec_mode = AM_U;
        case (cc)
            2'b01: begin
                dec_op = grp_op;
                case (bbb)
                    3'd0:    dec_mode = AM_INDX;
                    3'd1:    dec_mode = AM_ZP;
                    3'd2:    dec_mode = AM_IMM;
                    3'd3:    dec_mode = AM_ABS;
                    3'd4:    dec_mode = AM_INDY;
                    3'd5:    dec_mode = AM_ZPX;
                    3'd6:    dec_mode = AM_ABSY;
                    default: dec_mode = AM_ABSX;
                endcase
                if (instr == 8'h89) begin
                    dec_op   = OPC_U;
                    dec_mode = AM_U;
                end
            end
            2'b10: begin
                case (bbb)
                    3'd0: if (aaa == 3'd5) {dec_op, dec_mode} = {OPC_LDX, AM_IMM};
                    3'd1: {dec_op, dec_mode} = {grp_op, AM_ZP};
                    3'd2: begin
                        if (!aaa[2]) begin
                            {dec_op, dec_mode} = {grp_op, AM_ACC};
                        end else begin
                            dec_mode = AM_IMP;
                            case (aaa)
                                3'd4:    dec_op = OPC_TXA;
                                3'd5:    dec_op = OPC_TAX;
                                3'd6:    dec_op = OPC_DEX;
                                default: dec_op = OPC_NOP;
                            endcase
                        end
                    end
                    3'd3: {dec_op, dec_mode} = {grp_op, AM_ABS};
                    3'd5: begin
                        dec_op   = grp_op;
                        dec_mode = (aaa == 3'd4 || aaa == 3'd5) ? AM_ZPY : AM_ZPX;
                    end
                    3'd6: begin
                        if (aaa == 3'd4) {dec_op, dec_mode} = {OPC_TXS, AM_IMP};
                        if (aaa == 3'd5) {dec_op, dec_mode} = {OPC_TSX, AM_IMP};
                    end
                    3'd7: begin
                        if (aaa != 3'd4) begin
                            dec_op   = grp_op;
                            dec_mode = (aaa == 3'd5) ? AM_ABSY : AM_ABSX;
                        end
                    end
                    default: ;
                endcase
            end
            2'b00: begin
                // This column is irregular enough that a direct byte table is clearest.
                case (instr)
                    8'h00: {dec_op, dec_mode} = {OPC_BRK, AM_IMP};
                    8'h08: {dec_op, dec_mode} = {OPC_PHP, AM_IMP};
                    8'h10: {dec_op, dec_mode} = {OPC_BPL, AM_REL};
                    8'h18: {dec_op, dec_mode} = {OPC_CLC, AM_IMP};
                    8'h20: {dec_op, dec_mode} = {OPC_JSR, AM_ABS};
                    8'h24: {dec_op, dec_mode} = {OPC_BIT, AM_ZP};
                    8'h28: {dec_op, dec_mode} = {OPC_PLP, AM_IMP};
                    8'h2C: {dec_op, dec_mode} = {OPC_BIT, AM_ABS};
                    8'h30: {dec_op, dec_mode} = {OPC_BMI, AM_REL};
                    8'h38: {dec_op, dec_mode} = {OPC_SEC, AM_IMP};
                    8'h40: {dec_op, dec_mode} = {OPC_RTI, AM_IMP};
                    8'h48: {dec_op, dec_mode} = {OPC_PHA, AM_IMP};
                    8'h4C: {dec_op, dec_mode} = {OPC_JMP, AM_ABS};
                    8'h50: {dec_op, dec_mode} = {OPC_BVC, AM_REL};
                    8'h58: {dec_op, dec_mode} = {OPC_CLI, AM_IMP};
                    8'h60: {dec_op, dec_mode} = {OPC_RTS, AM_IMP};
                    8'h68: {dec_op, dec_mode} = {OPC_PLA, AM_IMP};
                    8'h6C: {dec_op, dec_mode} = {OPC_JMP, AM_IND};
                    8'h70: {dec_op, dec_mode} = {OPC_BVS, AM_REL};
                    8'h78: {dec_op, dec_mode} = {OPC_SEI, AM_IMP};
                    8'h84: {dec_op, dec_mode} = {OPC_STY, AM_ZP};
                    8'h88: {dec_op, dec_mode} = {OPC_DEY, AM_IMP};
                    8'h8C: {dec_op, dec_mode} = {OPC_STY, AM_ABS};
                    8'h90: {dec_op, dec_mode} = {OPC_BCC, AM_REL};
                    8'h94: {dec_op, dec_mode} = {OPC_STY, AM_ZPX};
                    8'h98: {dec_op, dec_mode} = {OPC_TYA, AM_IMP};
                    8'hA0: {dec_op, dec_mode} = {OPC_LDY, AM_IMM};
                    8'hA4: {dec_op, dec_mode} = {OPC_LDY, AM_ZP};
                    8'hA8: {dec_op, dec_mode} = {OPC_TAY, AM_IMP};
                    8'hAC: {dec_op, dec_mode} = {OPC_LDY, AM_ABS};
                    8'hB0: {dec_op, dec_mode} = {OPC_BCS, AM_REL};
                    8'hB4: {dec_op, dec_mode} = {OPC_LDY, AM_ZPX};
                    8'hB8: {dec_op, dec_mode} = {OPC_CLV, AM_IMP};
                    8'hBC: {dec_op, dec_mode} = {OPC_LDY, AM_ABSX};
                    8'hC0: {dec_op, dec_mode} = {OPC_CPY, AM_IMM};
                    8'hC4: {dec_op, dec_mode} = {OPC_CPY, AM_ZP};
                    8'hC8: {dec_op, dec_mode} = {OPC_INY, AM_IMP};
                    8'hCC: {dec_op, dec_mode} = {OPC_CPY, AM_ABS};
                    8'hD0: {dec_op, dec_mode} = {OPC_BNE, AM_REL};
                    8'hD8: {dec_op, dec_mode} = {OPC_CLD, AM_IMP};
                    8'hE0: {dec_op, dec_mode} = {OPC_CPX, AM_IMM};
                    8'hE4: {dec_op, dec_mode} = {OPC_CPX, AM_ZP};
                    8'hE8: {dec_op, dec_mode} = {OPC_INX, AM_IMP};
                    8'hEC: {dec_op, dec_mode} = {OPC_CPX, AM_ABS};
                    8'hF0: {dec_op, dec_mode} = {OPC_BEQ, AM_REL};
                    8'hF8: {dec_op, dec_mode} = {OPC_SED, AM_IMP};
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        opcode_d  = opcode_q;
        mode_d    = mode_q;
        illegal_d = illegal_q;
        if (en) begin
            opcode_d  = dec_op;
            mode_d    = dec_mode;
            illegal_d = (dec_mode == AM_U);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_q  <= OPC_U;
            mode_q    <= AM_U;
            illegal_q <= 1'b0;
        end else begin
            opcode_q  <= opcode_d;
            mode_q    <= mode_d;
            illegal_q <= illegal_d;
        end
    end

    assign opcode  = opcode_q;
    assign mode    = mode_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: an opcode-matrix reference table feeds a scoreboard
// queue that is compared against the registered decoder outputs.
module tb_instr_decode;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] instr = 8'h00;
    logic [5:0] opcode;
    logic [3:0] mode;
    logic       illegal;

    instr_decode dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .instr   (instr),
        .opcode  (opcode),
        .mode    (mode),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    localparam int N = -1;
    localparam int ADC=1,  AND=2,  ASL=3,  BCC=4,  BCS=5,  BEQ=6,  BIT=7,  BMI=8;
    localparam int BNE=9,  BPL=10, BRK=11, BVC=12, BVS=13, CLC=14, CLD=15, CLI=16;
    localparam int CLV=17, CMP=18, CPX=19, CPY=20, DEC=21, DEX=22, DEY=23, EOR=24;
    localparam int INC=25, INX=26, INY=27, JMP=28, JSR=29, LDA=30, LDX=31, LDY=32;
    localparam int LSR=33, NOP=34, ORA=35, PHA=36, PHP=37, PLA=38, PLP=39, ROL=40;
    localparam int ROR=41, RTI=42, RTS=43, SBC=44, SEC=45, SED=46, SEI=47, STA=48;
    localparam int STX=49, STY=50, TAX=51, TAY=52, TSX=53, TXA=54, TXS=55, TYA=56;
    localparam int IMP=1, ACC=2, IMM=3, ZP=4, ZPX=5, ZPY=6, ABS=7;
    localparam int ABSX=8, ABSY=9, IND=10, INDX=11, INDY=12, REL=13;

    typedef struct {
        int b;
        int op;
        int mode;
        int ill;
    } exp_t;

    int   m_op[256];
    int   m_mode[256];
    int   m_ill[256];
    exp_t sb[$];
    exp_t cur;
    int   n_pass = 0;
    int   n_total = 0;
    int   legal_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // One row per mnemonic; argument position k gives the byte for mode code k+1.
    task automatic row(input int op, input int imp, input int acc, input int imm,
                       input int zp, input int zpx, input int zpy, input int ab,
                       input int abx, input int aby, input int ind, input int inx,
                       input int iny, input int rel);
        int b[13];
        b = '{imp, acc, imm, zp, zpx, zpy, ab, abx, aby, ind, inx, iny, rel};
        for (int k = 0; k < 13; k++) begin
            if (b[k] >= 0) begin
                m_op[b[k]]   = op;
                m_mode[b[k]] = k + 1;
                m_ill[b[k]]  = 0;
            end
        end
    endtask

    task automatic build_table();
        for (int i = 0; i < 256; i++) begin
            m_op[i] = 0; m_mode[i] = 0; m_ill[i] = 1;
        end
        //  op   IMP  ACC  IMM   ZP    ZPX   ZPY   ABS   ABSX  ABSY  IND   INDX  INDY  REL
        row(ADC, N,   N,   'h69, 'h65, 'h75, N,    'h6D, 'h7D, 'h79, N,    'h61, 'h71, N);
        row(AND, N,   N,   'h29, 'h25, 'h35, N,    'h2D, 'h3D, 'h39, N,    'h21, 'h31, N);
        row(ASL, N,  'h0A, N,    'h06, 'h16, N,    'h0E, 'h1E, N,    N,    N,    N,    N);
        row(BCC, N,   N,   N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    'h90);
        row(BCS, N,   N,   N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    'hB0);
        row(BEQ, N,   N,   N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    'hF0);
        row(BIT, N,   N,   N,    'h24, N,    N,    'h2C, N,    N,    N,    N,    N,    N);
        row(BMI, N,   N,   N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    'h30);
        row(BNE, N,   N,   N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    'hD0);
        row(BPL, N,   N,   N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    'h10);
        row(BRK, 'h00, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(BVC, N,   N,   N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    'h50);
        row(BVS, N,   N,   N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    'h70);
        row(CLC, 'h18, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(CLD, 'hD8, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(CLI, 'h58, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(CLV, 'hB8, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(CMP, N,   N,   'hC9, 'hC5, 'hD5, N,    'hCD, 'hDD, 'hD9, N,    'hC1, 'hD1, N);
        row(CPX, N,   N,   'hE0, 'hE4, N,    N,    'hEC, N,    N,    N,    N,    N,    N);
        row(CPY, N,   N,   'hC0, 'hC4, N,    N,    'hCC, N,    N,    N,    N,    N,    N);
        row(DEC, N,   N,   N,    'hC6, 'hD6, N,    'hCE, 'hDE, N,    N,    N,    N,    N);
        row(DEX, 'hCA, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(DEY, 'h88, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(EOR, N,   N,   'h49, 'h45, 'h55, N,    'h4D, 'h5D, 'h59, N,    'h41, 'h51, N);
        row(INC, N,   N,   N,    'hE6, 'hF6, N,    'hEE, 'hFE, N,    N,    N,    N,    N);
        row(INX, 'hE8, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(INY, 'hC8, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(JMP, N,   N,   N,    N,    N,    N,    'h4C, N,    N,    'h6C, N,    N,    N);
        row(JSR, N,   N,   N,    N,    N,    N,    'h20, N,    N,    N,    N,    N,    N);
        row(LDA, N,   N,   'hA9, 'hA5, 'hB5, N,    'hAD, 'hBD, 'hB9, N,    'hA1, 'hB1, N);
        row(LDX, N,   N,   'hA2, 'hA6, N,    'hB6, 'hAE, N,    'hBE, N,    N,    N,    N);
        row(LDY, N,   N,   'hA0, 'hA4, 'hB4, N,    'hAC, 'hBC, N,    N,    N,    N,    N);
        row(LSR, N,  'h4A, N,    'h46, 'h56, N,    'h4E, 'h5E, N,    N,    N,    N,    N);
        row(NOP, 'hEA, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(ORA, N,   N,   'h09, 'h05, 'h15, N,    'h0D, 'h1D, 'h19, N,    'h01, 'h11, N);
        row(PHA, 'h48, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(PHP, 'h08, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(PLA, 'h68, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(PLP, 'h28, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(ROL, N,  'h2A, N,    'h26, 'h36, N,    'h2E, 'h3E, N,    N,    N,    N,    N);
        row(ROR, N,  'h6A, N,    'h66, 'h76, N,    'h6E, 'h7E, N,    N,    N,    N,    N);
        row(RTI, 'h40, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(RTS, 'h60, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(SBC, N,   N,   'hE9, 'hE5, 'hF5, N,    'hED, 'hFD, 'hF9, N,    'hE1, 'hF1, N);
        row(SEC, 'h38, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(SED, 'hF8, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(SEI, 'h78, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(STA, N,   N,   N,    'h85, 'h95, N,    'h8D, 'h9D, 'h99, N,    'h81, 'h91, N);
        row(STX, N,   N,   N,    'h86, N,    'h96, 'h8E, N,    N,    N,    N,    N,    N);
        row(STY, N,   N,   N,    'h84, 'h94, N,    'h8C, N,    N,    N,    N,    N,    N);
        row(TAX, 'hAA, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(TAY, 'hA8, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(TSX, 'hBA, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(TXA, 'h8A, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(TXS, 'h9A, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
        row(TYA, 'h98, N,  N,    N,    N,    N,    N,    N,    N,    N,    N,    N,    N);
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, then pop and
    // compare once the registered result is visible after the edge.
    task automatic apply(input int b, input bit e, input bit r);
        exp_t x;
        instr = b[7:0];
        en    = e;
        rst   = r;
        if (r)
            cur = '{b, 0, 0, 0};
        else if (e)
            cur = '{b, m_op[b], m_mode[b], m_ill[b]};
        x   = cur;
        x.b = b;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check($sformatf("opcode[%02h en=%0b rst=%0b]", x.b, e, r), opcode, x.op);
        check($sformatf("mode[%02h en=%0b rst=%0b]", x.b, e, r), mode, x.mode);
        check($sformatf("illegal[%02h en=%0b rst=%0b]", x.b, e, r), illegal, x.ill);
        $display("txn instr=%02h en=%0b rst=%0b -> opcode=%0d mode=%0d illegal=%0b",
                 b[7:0], e, r, opcode, mode, illegal);
    endtask

    initial begin
        int subset[];
        int bad[];
        cur = '{0, 0, 0, 0};
        build_table();
        @(negedge clk);

        // Reset held with a valid byte present, then released.
        apply('hE8, 1'b1, 1'b1);
        apply('hE8, 1'b1, 1'b1);
        apply('hE8, 1'b1, 1'b0);
        check("inx_opcode_const", opcode, 26);
        check("inx_mode_const", mode, 1);

        subset = '{'hA2, 'hA6, 'h4C, 'hF0, 'hD0, 'h0A, 'h8A, 'hB6, 'hBE, 'h6C, 'h20};
        foreach (subset[i]) apply(subset[i], 1'b1, 1'b0);
        bad = '{'h02, 'h89, 'h9E, 'hFF, 'h00};
        foreach (bad[i]) apply(bad[i], 1'b1, 1'b0);

        // Enable hold, then reset taking priority over a low enable.
        apply('hA9, 1'b1, 1'b0);
        apply('h60, 1'b0, 1'b0);
        apply('h60, 1'b0, 1'b0);
        check("hold_opcode_const", opcode, 30);
        check("hold_mode_const", mode, 3);
        apply('h60, 1'b1, 1'b0);
        apply('hA2, 1'b0, 1'b1);
        apply('hA2, 1'b1, 1'b0);

        legal_seen = 0;
        for (int b = 0; b < 256; b++) begin
            apply(b, 1'b1, 1'b0);
            if (illegal === 1'b0) legal_seen++;
        end
        check("legal_count", legal_seen, 151);
        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
